rvsteel_spi_target: RTL and testbench

- SPI target (responder) for the far end of the MCU's SPI controller port (sclk, pico, poci, cs).
- Lets a board-level test fixture or second FPGA design answer transfers issued by the MCU.
- Oversampled in the system clock domain: sclk, pico and cs are synchronised and edge-detected, with no SPI-clock-domain logic.
- Byte-oriented, MSB first, with a one-byte TX holding buffer and a per-byte RX strobe.

---
 rtl/rvsteel_spi_target.sv | 200 ++++++++++++++++++++
 tb/tb_rvsteel_spi_target.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_spi_target.sv
// rvsteel_spi_target: byte-oriented SPI target (responder), MSB first.
//
// The SPI pins are oversampled in the system clock domain. sclk, pico and
// cs pass through 2-flop synchronisers. sclk and cs also keep one previous
// value for edge detection, so a pin change becomes an event 3 clocks later.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   sclk, pico, cs     SPI inputs from the controller (asynchronous, cs active-low)
//   poci, poci_oe      target-out data and its output enable (high while selected)
//   tx_data/tx_valid   write into the one-byte TX holding buffer
//   tx_ready           holding buffer empty
//   rx_data/rx_valid   last complete received byte and its one-cycle strobe
//   tx_underrun        one-cycle strobe: a byte started with an empty buffer
//   busy               target is selected
//
// Parameters:
//   CPOL  idle level of sclk; the leading edge leaves this level
//   CPHA  0: sample on leading, shift on trailing; 1: shift on leading, sample on trailing
module rvsteel_spi_target #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic        sclk_s1_d, sclk_s2_d, sclk_prev_d;
  logic        pico_s1_q, pico_s2_q;
  logic        pico_s1_d, pico_s2_d;
  logic        cs_s1_q, cs_s2_q, cs_prev_q;
  logic        cs_s1_d, cs_s2_d, cs_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic        poci_q, poci_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_underrun_q, tx_underrun_d;

  logic        sclk_lead, sclk_trail, sample_edge, shift_edge;
  logic        cs_fall, cs_rise;
  logic        wr_en, load;

  assign sclk_lead   = (sclk_s2_q != CPOL) && (sclk_prev_q == CPOL);
  assign sclk_trail  = (sclk_s2_q == CPOL) && (sclk_prev_q != CPOL);
  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign shift_edge  = CPHA ? sclk_lead : sclk_trail;
  assign cs_fall     = cs_prev_q && !cs_s2_q;
  assign cs_rise     = !cs_prev_q && cs_s2_q;
  assign wr_en       = tx_valid && !buf_full_q;

  always_comb begin
    sclk_s1_d     = sclk;
    sclk_s2_d     = sclk_s1_q;
    sclk_prev_d   = sclk_s2_q;
    pico_s1_d     = pico;
    pico_s2_d     = pico_s1_q;
    cs_s1_d       = cs;
    cs_s2_d       = cs_s1_q;
    cs_prev_d     = cs_s2_q;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    poci_d        = poci_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        poci_d    = 1'b0;
        bit_cnt_d = 3'd0;
        if (cs_fall) begin
          state_d = ACTIVE;
          // CPHA=0 must present the MSB before the first leading edge.
          load    = !CPHA;
        end
      end
      ACTIVE: begin
        // A cs edge wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_d   = IDLE;
          poci_d    = 1'b0;
          bit_cnt_d = 3'd0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[6:0], pico_s2_q};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], pico_s2_q};
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (shift_edge) begin
          // Count 0 on a shift edge marks a byte boundary: fetch the next byte.
          if (bit_cnt_q == 3'd0) begin
            load = 1'b1;
          end else begin
            poci_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        poci_d     = buf_q[7];
      end else begin
        tx_shift_d    = 8'h00;
        poci_d        = 1'b0;
        tx_underrun_d = 1'b1;
      end
      buf_full_d = 1'b0;
    end

    // The load above saw the buffer as it was before this cycle's write,
    // so a coincident write survives for the following byte.
    if (wr_en) begin
      buf_full_d = 1'b1;
      buf_d      = tx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_s1_q     <= CPOL;
      sclk_s2_q     <= CPOL;
      sclk_prev_q   <= CPOL;
      pico_s1_q     <= 1'b0;
      pico_s2_q     <= 1'b0;
      cs_s1_q       <= 1'b1;
      cs_s2_q       <= 1'b1;
      cs_prev_q     <= 1'b1;
      bit_cnt_q     <= 3'd0;
      tx_shift_q    <= 8'h00;
      rx_shift_q    <= 8'h00;
      buf_q         <= 8'h00;
      buf_full_q    <= 1'b0;
      poci_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_s1_q     <= sclk_s1_d;
      sclk_s2_q     <= sclk_s2_d;
      sclk_prev_q   <= sclk_prev_d;
      pico_s1_q     <= pico_s1_d;
      pico_s2_q     <= pico_s2_d;
      cs_s1_q       <= cs_s1_d;
      cs_s2_q       <= cs_s2_d;
      cs_prev_q     <= cs_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      poci_q        <= poci_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign poci        = poci_q;
  assign poci_oe     = (state_q == ACTIVE);
  assign busy        = (state_q == ACTIVE);
  assign tx_ready    = !buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// Bench for rvsteel_spi_target: one mode-0 and one mode-3 instance share the
// clock, reset, pico and tx_data; sel routes cs/sclk/tx_valid to one of them.
// The idle instance sees cs high and sclk at its idle level.
module tb_rvsteel_spi_target;
  localparam int H = 5;  // sclk half period in system clocks

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, sel, sclk, pico, cs, tx_valid;
  logic [7:0] tx_data;

  logic       sclk0, cs0, txv0, sclk3, cs3, txv3;
  logic       poci0, oe0, rdy0, rxv0, und0, busy0;
  logic       poci3, oe3, rdy3, rxv3, und3, busy3;
  logic [7:0] rxd0, rxd3;
  logic       poci_s, oe_s, rdy_s, busy_s;
  logic [7:0] rxd_s;

  assign sclk0  = sel ? 1'b0 : sclk;
  assign cs0    = sel ? 1'b1 : cs;
  assign txv0   = sel ? 1'b0 : tx_valid;
  assign sclk3  = sel ? sclk : 1'b1;
  assign cs3    = sel ? cs : 1'b1;
  assign txv3   = sel ? tx_valid : 1'b0;
  assign poci_s = sel ? poci3 : poci0;
  assign oe_s   = sel ? oe3 : oe0;
  assign rdy_s  = sel ? rdy3 : rdy0;
  assign busy_s = sel ? busy3 : busy0;
  assign rxd_s  = sel ? rxd3 : rxd0;

  rvsteel_spi_target #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clock(clock), .reset(reset), .sclk(sclk0), .pico(pico), .cs(cs0),
    .poci(poci0), .poci_oe(oe0), .tx_data(tx_data), .tx_valid(txv0),
    .tx_ready(rdy0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_underrun(und0), .busy(busy0));

  rvsteel_spi_target #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .clock(clock), .reset(reset), .sclk(sclk3), .pico(pico), .cs(cs3),
    .poci(poci3), .poci_oe(oe3), .tx_data(tx_data), .tx_valid(txv3),
    .tx_ready(rdy3), .rx_data(rxd3), .rx_valid(rxv3),
    .tx_underrun(und3), .busy(busy3));

  // Reference model: buffer occupancy, expected underruns, last good RX byte.
  bit         m_full[2];
  logic [7:0] m_val[2];
  logic [7:0] m_last_rx[2];
  int         exp_und[2];
  int         seen_und[2];
  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx3[$];
  logic [7:0] mosi[4];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-start rule: take the buffered byte, or send zeros and flag underrun.
  function automatic logic [7:0] m_load(input int d);
    if (m_full[d]) begin
      m_full[d] = 1'b0;
      return m_val[d];
    end
    exp_und[d]++;
    return 8'h00;
  endfunction

  // Monitor: every rx_valid pulse consumes one expected byte.
  logic [7:0] mon_e;
  always @(negedge clock) begin
    if (rxv0) begin
      if (exp_rx0.size() == 0) check("unexpected rx_valid m0", {24'd0, rxd0}, 32'hFFFF_FFFF);
      else begin mon_e = exp_rx0.pop_front(); check("rx_data m0", {24'd0, rxd0}, {24'd0, mon_e}); end
    end
    if (rxv3) begin
      if (exp_rx3.size() == 0) check("unexpected rx_valid m3", {24'd0, rxd3}, 32'hFFFF_FFFF);
      else begin mon_e = exp_rx3.pop_front(); check("rx_data m3", {24'd0, rxd3}, {24'd0, mon_e}); end
    end
    if (und0) seen_und[0]++;
    if (und3) seen_und[1]++;
  end

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [7:0] v);
    int d = sel;
    check("tx_ready before write", {31'd0, rdy_s}, {31'd0, !m_full[d]});
    tx_data  = v;
    tx_valid = 1'b1;
    @(posedge clock);
    #2;
    tx_valid = 1'b0;
    m_full[d] = 1'b1;
    m_val[d]  = v;
  endtask

  task automatic check_reset_outputs();
    check("reset outputs m0", {18'd0, poci0, oe0, rdy0, rxd0, rxv0, und0, busy0},
          {18'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    check("reset outputs m3", {18'd0, poci3, oe3, rdy3, rxd3, rxv3, und3, busy3},
          {18'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  // One cs assertion carrying nbytes from mosi[]; the last carries last_bits.
  // refill_k: byte during which a buffer write happens (after its 4th bit).
  // wr_at_load: write in the very cycle of the cs-fall load (mode 0 only).
  task automatic xfer(input int nbytes, input int last_bits, input int refill_k,
                      input logic [7:0] refill_v, input bit wr_at_load,
                      input logic [7:0] load_wr_v);
    int d = sel;
    bit cpol = sel;
    bit cpha = sel;
    logic [7:0] exp_tx, got, mask;
    int nb;
    for (int k = 0; k < nbytes; k++) begin
      if (k < nbytes - 1 || last_bits == 8) begin
        if (d == 0) exp_rx0.push_back(mosi[k]); else exp_rx3.push_back(mosi[k]);
        m_last_rx[d] = mosi[k];
      end
    end
    exp_tx = 8'h00;
    sclk = cpol;
    pico = mosi[0][7];
    cs = 1'b0;
    if (wr_at_load) begin
      exp_tx = m_load(d);
      clk(2);
      wr(load_wr_v);
      clk(H - 3);
    end else begin
      clk(H);
    end
    for (int k = 0; k < nbytes; k++) begin
      if (k > 0 || !wr_at_load) exp_tx = m_load(d);
      nb = (k == nbytes - 1) ? last_bits : 8;
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          sclk = 1'b1;
          got[7-i] = poci_s;
          clk(H);
          sclk = 1'b0;
          if (i < 7) pico = mosi[k][6-i];
          else if (k + 1 < nbytes) pico = mosi[k+1][7];
          else pico = 1'b0;
          clk(H);
        end else begin
          sclk = 1'b0;
          pico = mosi[k][7-i];
          clk(H);
          sclk = 1'b1;
          got[7-i] = poci_s;
          clk(H);
        end
        if (k == 0 && i == 0) check("busy/poci_oe while selected", {30'd0, busy_s, oe_s}, 32'd3);
        if (k == refill_k && i == 3) wr(refill_v);
      end
      mask = 8'hFF;
      mask = mask << (8 - nb);
      check("poci byte", {24'd0, got & mask}, {24'd0, exp_tx & mask});
    end
    // Mode 0: the final trailing edge is a byte boundary and performs a load.
    if (!cpha && last_bits == 8) void'(m_load(d));
    cs = 1'b1;
    clk(2 * H);
    check("underrun count", seen_und[d], exp_und[d]);
    check("pending rx bytes", (d == 0) ? exp_rx0.size() : exp_rx3.size(), 0);
    check("rx_data after transfer", {24'd0, rxd_s}, {24'd0, m_last_rx[d]});
    check("idle busy/poci_oe", {30'd0, busy_s, oe_s}, 32'd0);
    check("tx_ready after transfer", {31'd0, rdy_s}, {31'd0, !m_full[d]});
  endtask

  task automatic select(input bit s);
    if (sel != s) begin
      sel  = s;
      sclk = s;
      clk(4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeds limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit s;
    int nbytes, lastb, rk;
    reset = 1'b1; sel = 1'b0; sclk = 1'b0; cs = 1'b1; pico = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0; m_val[d] = 8'h00; m_last_rx[d] = 8'h00;
      exp_und[d] = 0; seen_und[d] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    clk(4);

    // Mode 0 single byte with a prepared TX byte.
    wr(8'hA5);
    mosi[0] = 8'h3C;
    xfer(1, 8, -1, 8'h00, 1'b0, 8'h00);

    // Mode 3 two-byte burst, buffer refilled during byte 1.
    select(1'b1);
    wr(8'h5A);
    mosi[0] = 8'hC7; mosi[1] = 8'h1E;
    xfer(2, 8, 0, 8'h81, 1'b0, 8'h00);

    // Underrun: nothing written before the transfer.
    mosi[0] = 8'hFF;
    xfer(1, 8, -1, 8'h00, 1'b0, 8'h00);

    // cs rises after 5 bits; then a complete transfer.
    select(1'b0);
    mosi[0] = 8'hC3;
    xfer(1, 5, -1, 8'h00, 1'b0, 8'h00);
    wr(8'h6E);
    mosi[0] = 8'h12;
    xfer(1, 8, -1, 8'h00, 1'b0, 8'h00);

    // Reset mid-byte with the buffer full.
    wr(8'h77);
    mosi[0] = 8'h96;
    sclk = 1'b0; pico = mosi[0][7]; cs = 1'b0;
    clk(H);
    begin
      logic [7:0] e, g;
      e = m_load(0);
      g = 8'h00;
      for (int i = 0; i < 3; i++) begin
        sclk = 1'b1; g[7-i] = poci_s; clk(H);
        sclk = 1'b0; pico = mosi[0][6-i]; clk(H);
      end
      check("poci before reset", {24'd0, g & 8'hE0}, {24'd0, e & 8'hE0});
    end
    wr(8'h99);
    check("tx_ready with buffer full", {31'd0, rdy_s}, 32'd0);
    reset = 1'b1; cs = 1'b1; sclk = 1'b0;
    @(posedge clock);
    #1;
    check_reset_outputs();
    for (int d = 0; d < 2; d++) begin m_full[d] = 1'b0; m_last_rx[d] = 8'h00; end
    clk(3);
    reset = 1'b0;
    clk(4);
    wr(8'h42);
    mosi[0] = 8'hE9;
    xfer(1, 8, -1, 8'h00, 1'b0, 8'h00);

    // Write in the same cycle as the cs-fall load with an empty buffer.
    mosi[0] = 8'h55; mosi[1] = 8'hAA;
    xfer(2, 8, -1, 8'h00, 1'b1, 8'hB4);

    // Randomised transfers on both instances.
    for (int t = 0; t < 8; t++) begin
      s = 1'($urandom_range(0, 1));
      select(s);
      nbytes = $urandom_range(1, 3);
      lastb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      rk     = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nbytes - 1) : -1;
      for (int k = 0; k < 4; k++) mosi[k] = 8'($urandom_range(0, 255));
      if (!m_full[sel] && $urandom_range(0, 2) != 0) wr(8'($urandom_range(0, 255)));
      xfer(nbytes, lastb, rk, 8'($urandom_range(0, 255)), 1'b0, 8'h00);
    end

    clk(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
